muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 116 +++++++++++
 tb/tb_muldiv_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (radix-2 shift-add multiply, restoring divide)
module muldiv_unit #(
    parameter int DATA_SIZE = 32,
    parameter int CNT_SIZE  = $clog2(DATA_SIZE) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_i,
    input  logic [2:0]           func_i,
    input  logic [DATA_SIZE-1:0] op_a_i,
    input  logic [DATA_SIZE-1:0] op_b_i,
    input  logic                 kill_i,
    output logic                 ready_o,
    output logic                 done_o,
    output logic [DATA_SIZE-1:0] result_o
);
    localparam int W = DATA_SIZE;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;
    logic [2:0]          func_q, func_d;
    logic [W-1:0]        opnd_q, opnd_d;
    logic [2*W-1:0]      acc_q, acc_d;
    logic                neg_q, neg_d, spec_q, spec_d;

    logic                a_sgn, b_sgn, div_zero, ovf, special;
    logic [W-1:0]        a_mag, b_mag, spec_res;
    logic [W:0]          sum, shifted, diff;
    logic [2*W-1:0]      mul_step, div_step, prod_s;
    logic [W-1:0]        div_sel, div_res, mul_res, res;

    // Decode the incoming request: operand signs, magnitudes and the divide special cases
    always_comb begin
        a_sgn    = op_a_i[W-1] && (func_i == 3'd1 || func_i == 3'd2 || func_i == 3'd4 || func_i == 3'd6);
        b_sgn    = op_b_i[W-1] && (func_i == 3'd1 || func_i == 3'd4 || func_i == 3'd6);
        a_mag    = a_sgn ? -op_a_i : op_a_i;
        b_mag    = b_sgn ? -op_b_i : op_b_i;
        div_zero = func_i[2] && (op_b_i == '0);
        ovf      = func_i[2] && !func_i[0] && (op_a_i == {1'b1, {(W-1){1'b0}}}) && (&op_b_i);
        special  = div_zero || ovf;
        spec_res = div_zero ? (func_i[1] ? op_a_i : '1) : (func_i[1] ? '0 : op_a_i);
    end

    // One iteration of each algorithm: acc holds {high product, multiplier} or {remainder, quotient}
    always_comb begin
        sum      = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        mul_step = {sum, acc_q[W-1:1]};
        shifted  = {acc_q[2*W-1:W], acc_q[W-1]};
        diff     = shifted - {1'b0, opnd_q};
        div_step = diff[W] ? {shifted[W-1:0], acc_q[W-2:0], 1'b0} : {diff[W-1:0], acc_q[W-2:0], 1'b1};
    end

    // Next-state logic: accept in IDLE, iterate in CALC, kill returns to IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        func_d  = func_q;
        opnd_d  = opnd_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        spec_d  = spec_q;
        if (state_q == IDLE) begin
            if (valid_i && !kill_i) begin
                state_d = special ? DONE : CALC;
                cnt_d   = '0;
                func_d  = func_i;
                opnd_d  = func_i[2] ? b_mag : a_mag;
                acc_d   = {{W{1'b0}}, special ? spec_res : (func_i[2] ? a_mag : b_mag)};
                neg_d   = (func_i[2] && func_i[1]) ? a_sgn : (a_sgn ^ b_sgn);
                spec_d  = special;
            end
        end else if (kill_i || state_q == DONE) begin
            state_d = IDLE;
        end else begin
            cnt_d   = cnt_q + CNT_SIZE'(1);
            acc_d   = func_q[2] ? div_step : mul_step;
            state_d = (cnt_q == CNT_SIZE'(W - 1)) ? DONE : CALC;
        end
    end

    // Sign fix-up and result selection, presented only while DONE
    always_comb begin
        prod_s   = neg_q ? -acc_q : acc_q;
        mul_res  = (func_q == 3'd0) ? prod_s[W-1:0] : prod_s[2*W-1:W];
        div_sel  = func_q[1] ? acc_q[2*W-1:W] : acc_q[W-1:0];
        div_res  = neg_q ? -div_sel : div_sel;
        res      = spec_q ? acc_q[W-1:0] : (func_q[2] ? div_res : mul_res);
        ready_o  = !rst_n || state_q == IDLE;
        done_o   = rst_n && state_q == DONE;
        result_o = done_o ? res : '0;
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            func_q  <= '0;
            opnd_q  <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            spec_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            func_q  <= func_d;
            opnd_q  <= opnd_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            spec_q  <= spec_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors, corner sequences and random ops against an arithmetic reference
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_i = 1'b0;
    logic [2:0]  func_i = '0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        kill_i = 1'b0;
    logic        ready_o, done_o;
    logic [31:0] result_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    muldiv_unit #(.DATA_SIZE(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .func_i(func_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .kill_i(kill_i),
        .ready_o(ready_o), .done_o(done_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, rv;
        logic [63:0] p;
        sa = $signed(a);
        sb = $signed(b);
        ub = longint'({32'b0, b});
        case (f)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin rv = sa * sb; return rv[63:32]; end
            3'd2: begin rv = sa * ub; return rv[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                rv = sa / sb;
                return rv[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                rv = sa % sb;
                return rv[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 33;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one request, scramble inputs after accept, count edges (accept edge = 1) until done
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output int lat);
        int guard = 0;
        int nz = 0;
        @(negedge clk);
        while (!ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!ready_o) check("ready_wait", {31'b0, ready_o}, 32'd1);
        func_i = f; op_a_i = a; op_b_i = b; valid_i = 1'b1;
        lat = 0;
        r = 32'hDEAD_BEEF;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                valid_i = 1'b0;
                func_i = 3'($urandom);
                op_a_i = $urandom;
                op_b_i = $urandom;
            end
            if (done_o) begin
                r = result_o;
                break;
            end
            if (result_o != 0) nz++;
        end
        check("result_zero_when_idle", 32'(nz), 32'd0);
        @(negedge clk);
        check("done_one_cycle", {30'b0, done_o, ready_o}, 32'b01);
    endtask

    initial begin
        logic [31:0] r, a, b;
        logic [2:0]  f;
        int          lat, seen, n, cyc;
        int          t[3];

        vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14,        33};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2,         33};
        vecs[8]  = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'd5,         32'd0,         32'd5,         1};
        vecs[12] = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF, 1};
        vecs[13] = '{3'd0, 32'd0,         32'h0001_2345, 32'd0,         33};
        vecs[14] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
        vecs[15] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         33};
        vecs[16] = '{3'd7, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1};

        // reset: outputs idle while held, valid ignored under reset
        valid_i = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, ready_o}, 32'd1);
        check("rst_done", {31'b0, done_o}, 32'd0);
        check("rst_result", result_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b0;
        @(negedge clk);
        check("post_rst_ready_done", {30'b0, ready_o, done_o}, 32'b10);
        check("post_rst_result", result_o, 32'd0);

        for (int i = 0; i < 17; i++) begin
            do_op(vecs[i].f, vecs[i].a, vecs[i].b, r, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // kill together with valid in IDLE: no accept
        @(negedge clk);
        valid_i = 1'b1; kill_i = 1'b1; func_i = 3'd0; op_a_i = 32'd9; op_b_i = 32'd9;
        repeat (3) @(negedge clk);
        check("kill_idle_not_accepted", {30'b0, ready_o, done_o}, 32'b10);
        valid_i = 1'b0; kill_i = 1'b0;

        // kill at CALC cycle 10
        @(negedge clk);
        func_i = 3'd0; op_a_i = 32'd123; op_b_i = 32'd456; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        check("calc_not_ready", {31'b0, ready_o}, 32'd0);
        repeat (9) @(negedge clk);
        kill_i = 1'b1;
        @(negedge clk);
        kill_i = 1'b0;
        check("kill_ready", {31'b0, ready_o}, 32'd1);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check("kill_no_done", 32'(seen), 32'd0);
        do_op(3'd0, 32'd3, 32'd4, r, lat);
        check("after_kill_mul", r, 32'd12);
        check("after_kill_lat", 32'(lat), 32'd33);

        // reset at CALC cycle 20
        @(negedge clk);
        func_i = 3'd5; op_a_i = 32'd999; op_b_i = 32'd3; valid_i = 1'b1;
        @(negedge clk);
        valid_i = 1'b0;
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready_o}, 32'd1);
        check("midrst_result", result_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("midrst_after_ready", {30'b0, ready_o, done_o}, 32'b10);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen++;
        end
        check("midrst_no_done", 32'(seen), 32'd0);

        // back-to-back DIVU with valid held
        @(negedge clk);
        func_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd7; valid_i = 1'b1;
        t = '{0, 0, 0};
        n = 0; cyc = 0;
        while (cyc < 150 && n < 3) begin
            @(negedge clk);
            cyc++;
            if (done_o) begin
                check("b2b_result", result_o, 32'd142);
                t[n] = cyc;
                n++;
            end
        end
        valid_i = 1'b0;
        check("b2b_count", 32'(n), 32'd3);
        check("b2b_gap1", 32'(t[1] - t[0]), 32'd34);
        check("b2b_gap2", 32'(t[2] - t[1]), 32'd34);

        // random operations against the reference model
        for (int i = 0; i < 150; i++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            do_op(f, a, b, r, lat);
            check($sformatf("rnd%0d_f%0d_%h_%h", i, f, a, b), r, ref_model(f, a, b));
            check($sformatf("rnd%0d_lat", i), 32'(lat), 32'(ref_lat(f, a, b)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
